// File: rtl/serial_sub_64_pkg.sv
// Shared ALU package: state encodings and default datapath width for the
// bit-serial subtractor.
package serial_sub_64_pkg;

  localparam int DEFAULT_WIDTH = 64;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_sub_64_add_1bit.sv
// Single full-adder cell shared by the serial ALU datapaths.
module add_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry of the three input bits
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_sub_64.sv
// Bit-serial subtractor: diff = a - b computed LSB first as a + ~b + 1
// through one full-adder cell and one carry flop, with Y86 ZF/SF/OF and a
// borrow flag registered on the final bit.
module serial_sub_64
  import serial_sub_64_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cf
);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             a_msb;
  logic             b_msb;

  logic             s;
  logic             carry_next;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] final_diff;

  // The subtrahend is inverted bit by bit on its way into the cell; the +1
  // comes from the carry being preset to 1 on accept.
  add_1bit u_cell (
    .a    (a_sh[0]),
    .b    (~b_sh[0]),
    .cin  (carry),
    .s    (s),
    .cout (carry_next)
  );

  // Status decode and the value the result register takes on the last bit
  always_comb begin
    ready      = (state == S_IDLE) || (state == S_DONE);
    busy       = (state == S_RUN);
    done       = (state == S_DONE);
    accept     = start && ready;
    last_bit   = (count == CNT_W'(WIDTH - 1));
    final_diff = {s, r_sh[WIDTH-1:1]};
  end

  // Sequencer: IDLE/DONE accept a start, RUN counts one bit per edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            count <= '0;
          end
        end
        S_RUN: begin
          if (last_bit) begin
            state <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_RUN;
            count <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Datapath: load operands on accept, shift one bit per RUN edge, and
  // register the result and flags together on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b1;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      zf    <= 1'b0;
      sf    <= 1'b0;
      of    <= 1'b0;
      cf    <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      carry <= 1'b1;
    end else if (state == S_RUN) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      r_sh  <= final_diff;
      carry <= carry_next;
      if (last_bit) begin
        diff <= final_diff;
        zf   <= (final_diff == '0);
        sf   <= s;
        of   <= (a_msb != b_msb) && (s != a_msb);
        cf   <= ~carry_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_64.sv
// Self-checking bench for serial_sub_64: a reference model pushes expected
// results when an operation is accepted and a monitor pops and compares
// them on every done pulse.
module tb_serial_sub_64;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] diff;
    logic         zf;
    logic         sf;
    logic         of;
    logic         cf;
    int           accCycle;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         zf;
  logic         sf;
  logic         of;
  logic         cf;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  exp_t sbQ[$];
  int   doneLog[$];
  exp_t lastExp;

  serial_sub_64 #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .zf    (zf),
    .sf    (sf),
    .of    (of),
    .cf    (cf)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Counts one comparison and reports it if the values differ
  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model of the subtract and its flags
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input int acc);
    exp_t e;
    e.diff     = av - bv;
    e.zf       = (e.diff == '0);
    e.sf       = e.diff[W-1];
    e.of       = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
    e.cf       = (av < bv);
    e.accCycle = acc;
    return e;
  endfunction

  // Drives one start pulse and records the expectation at the accept edge;
  // the operands are scrambled straight afterwards
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    checkOutput("ready_before_start", {63'd0, ready}, 64'd1);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    sbQ.push_back(model(av, bv, cycle));
    lastExp = model(av, bv, cycle);
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  // Waits, with a cycle budget, until every expected result has been seen
  task automatic waitDrain();
    for (int i = 0; i < 300 && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
  endtask

  // Monitor: compare each done pulse against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      doneLog.push_back(cycle);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("diff", diff, e.diff);
        checkOutput("zf", {63'd0, zf}, {63'd0, e.zf});
        checkOutput("sf", {63'd0, sf}, {63'd0, e.sf});
        checkOutput("of", {63'd0, of}, {63'd0, e.of});
        checkOutput("cf", {63'd0, cf}, {63'd0, e.cf});
        checkOutput("latency", 64'(cycle - e.accCycle), 64'd64);
      end
    end
  end

  initial begin
    // Reset state
    #3;
    checkOutput("rst_ready", {63'd0, ready}, 64'd1);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_diff", diff, 64'd0);
    checkOutput("rst_flags", {60'd0, zf, sf, of, cf}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic subtracts and boundary cases
    applyStimulus(64'd5, 64'd3);
    @(negedge clk);
    checkOutput("busy_in_run", {63'd0, busy}, 64'd1);
    checkOutput("not_ready_in_run", {63'd0, ready}, 64'd0);
    waitDrain();
    applyStimulus(64'd0, 64'd1);
    waitDrain();
    applyStimulus(64'h8000_0000_0000_0000, 64'd1);
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("diff_held", diff, lastExp.diff);

    // Equal operands, with a start pulse during RUN that must be ignored
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    repeat (10) @(negedge clk);
    a = 64'd9;
    b = 64'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_ignored_start", {63'd0, busy}, 64'd1);
    waitDrain();
    @(negedge clk);
    checkOutput("idle_after_equal", {63'd0, ready}, 64'd1);

    // Back-to-back: start held high, second op accepted in the DONE cycle
    doneLog.delete();
    @(negedge clk);
    a = 64'h0000_0000_0000_0100;
    b = 64'h0000_0000_0000_0200;
    start = 1'b1;
    @(posedge clk);
    #1;
    sbQ.push_back(model(64'h100, 64'h200, cycle));
    a = 64'h7FFF_FFFF_FFFF_FFFF;
    b = 64'hFFFF_FFFF_FFFF_FFFF;
    begin : waitFirstDone
      for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    end
    checkOutput("b2b_first_done_seen", {63'd0, done}, 64'd1);
    @(posedge clk);
    #1;
    sbQ.push_back(model(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, cycle));
    start = 1'b0;
    a = 64'hDEAD_BEEF_0000_0001;
    b = 64'h0000_0000_0000_0002;
    waitDrain();
    checkOutput("b2b_done_count", 64'(doneLog.size()), 64'd2);
    if (doneLog.size() >= 2)
      checkOutput("b2b_gap", 64'(doneLog[1] - doneLog[0]), 64'd65);

    // Asynchronous reset in the middle of RUN aborts the operation
    applyStimulus(64'd1000, 64'd1);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sbQ.delete();
    checkOutput("abort_ready", {63'd0, ready}, 64'd1);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_diff", diff, 64'd0);
    checkOutput("abort_flags", {60'd0, zf, sf, of, cf}, 64'd0);
    doneLog.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    checkOutput("abort_no_done", 64'(doneLog.size()), 64'd0);
    applyStimulus(64'd1000, 64'd1);
    waitDrain();

    // A few random operands
    for (int i = 0; i < 4; i++) begin
      applyStimulus({$urandom, $urandom}, {$urandom, $urandom});
      waitDrain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub_64.md
Name: serial_sub_64

Overview:
- Bit-serial subtractor for the Y86 ALU. Computes diff = a - b, one bit per clock, LSB first.
- Implemented as a + ~b + 1 through a single full-adder cell plus one carry flop.
- Produces the Y86-style condition flags (ZF, SF, OF) and a borrow flag.
- Small-area alternative to the ripple SUB path, used for compare/subtract when latency is acceptable.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range ≥ 2.
- CNT_W, 6, counter width; must satisfy 2^CNT_W ≥ WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- ready  output  1  high in IDLE and DONE (start will be accepted)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result and flags valid
- diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next completion
- zf  output  1  diff == 0
- sf  output  1  diff[WIDTH-1]
- of  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])
- cf  output  1  borrow = ~carry_out; 1 when unsigned a < b

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, count=0, carry=1.
  - Operand and result shift registers = 0.
  - diff=0, zf=0, sf=0, of=0, cf=0, done=0, busy=0, ready=1.
- States: IDLE, RUN, DONE. Transitions:
  - IDLE: start → RUN, else stay.
  - RUN: count==WIDTH-1 → DONE, else stay with count+1.
  - DONE: start → RUN, else → IDLE.
- Accept edge (start && ready):
  - Load a_sh=a, b_sh=b; save a[MSB] and b[MSB] for the OF calculation.
  - Set carry=1, count=0. No result yet.
- Each RUN edge:
  - s = a_sh[0] ^ ~b_sh[0] ^ carry.
  - carry ← majority(a_sh[0], ~b_sh[0], carry).
  - a_sh and b_sh shift right 1; s shifts into r_sh[MSB] (r_sh shifts right).
- Final RUN edge (count==WIDTH-1):
  - diff ← {s, r_sh[WIDTH-1:1]}.
  - Flags computed from that final value; cf ← ~carry_next.
  - All registered on this same edge.
- Latency: start sampled at edge k → diff/flags update at edge k+WIDTH.
  - done is high for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
- start while busy is ignored, with no effect on the operation in flight.
- start in DONE is accepted: back-to-back operations, one idle cycle between them.
- diff and flags are not cleared on a new start; they change only on completion or reset.
- a and b may change freely after the accept edge.
- Reset mid-RUN aborts immediately to reset values; no done pulse is produced.
- Arithmetic:
  - Pure modulo 2^WIDTH.
  - ~b is per-bit inversion inside the cell.
  - No sign extension; the counter never wraps past WIDTH-1.

Decomposition:
- Shared ALU package holds:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH=64.
- Sub-module: the existing add_1bit full-adder cell, instantiated once with inputs a_sh[0], ~b_sh[0], carry.
  - It supplies s and carry_next; all other logic is inline.

Test Plan:
- a=5, b=3, start 1 cycle → done exactly 64 cycles after the accept edge; diff=2, zf=0, sf=0, of=0, cf=0.
- a=0, b=1 → diff=0xFFFF_FFFF_FFFF_FFFF, sf=1, cf=1, zf=0, of=0.
- a=0x8000_0000_0000_0000, b=1 → diff=0x7FFF_FFFF_FFFF_FFFF, of=1, sf=0, cf=0.
- a=b=0x1234_5678_9ABC_DEF0 → diff=0, zf=1. Then pulse start at cycle 10 of RUN with a=9, b=1 → ignored; result still 0, busy stays 1.
- Back-to-back: start held high → second op accepted in the DONE cycle; two done pulses exactly 65 cycles apart. Operands changed after accept do not affect the result.
- Assert rst_n=0 at RUN cycle 30 → all outputs zero, ready=1 immediately (asynchronous); no done pulse. A new op after release gives the correct result.
